// File: rtl/sqrt_out_fifo.sv
// Show-ahead result FIFO behind the square-root controller.
// Optional root check enabled by defining SQRT_OUT_CHECK_EN.
module sqrt_out_fifo #(
  parameter int DEPTH = 4,
  parameter int R_W   = 8,
  parameter int X_W   = 8,
  parameter int CNT_W = 8
) (
  input  logic                     clk_i,
  input  logic                     enb_i,
  input  logic                     res_valid_i,
  input  logic [R_W-1:0]           res_r_i,
  input  logic [X_W-1:0]           res_x_i,
  output logic                     res_ready_o,
  output logic                     out_valid_o,
  output logic [R_W-1:0]           out_r_o,
  output logic [X_W-1:0]           out_x_o,
  input  logic                     out_ready_i,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic [CNT_W-1:0]         drop_cnt_o,
  output logic                     chk_err_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int DW = R_W + X_W;

  logic [DW-1:0]    mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [CNT_W-1:0] drop_cnt;
  logic             full;
  logic             push;
  logic             pop;
  logic             drop;

  // full/ready come from registered count only, never from a same-cycle pop
  assign full  = (count == CW'(DEPTH));
  assign push  = res_valid_i & ~full;
  assign drop  = res_valid_i & full;
  assign pop   = (count != '0) & out_ready_i;

  assign full_o      = full;
  assign res_ready_o = ~full;
  assign out_valid_o = (count != '0);
  assign count_o     = count;
  assign drop_cnt_o  = drop_cnt;

  // head entry shown combinationally from storage
  assign {out_r_o, out_x_o} = mem[rd_ptr];

  // storage array, deliberately left uncleared by reset
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr] <= {res_r_i, res_x_i};
    end
  end

  // pointers and occupancy
  always_ff @(posedge clk_i or negedge enb_i) begin
    if (!enb_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case (1'b1)
        (push & ~pop): count <= count + 1'b1;
        (pop & ~push): count <= count - 1'b1;
        default:       count <= count;
      endcase
    end
  end

  // saturating count of pushes rejected while full
  always_ff @(posedge clk_i or negedge enb_i) begin
    if (!enb_i) begin
      drop_cnt <= '0;
    end else if (drop && (drop_cnt != '1)) begin
      drop_cnt <= drop_cnt + 1'b1;
    end
  end

`ifdef SQRT_OUT_CHECK_EN
  localparam int PW0 = 2 * R_W + 2;
  localparam int PW  = (PW0 > X_W) ? PW0 : X_W;

  logic [PW-1:0] r_ext;
  logic [PW-1:0] r_inc;
  logic [PW-1:0] x_ext;
  logic [PW-1:0] sq_lo;
  logic [PW-1:0] sq_hi;
  logic          bad;
  logic          chk_err;

  assign r_ext = PW'(res_r_i);
  assign r_inc = r_ext + 1'b1;
  assign x_ext = PW'(res_x_i);
  assign sq_lo = r_ext * r_ext;
  assign sq_hi = r_inc * r_inc;
  assign bad   = ~((sq_lo <= x_ext) && (x_ext < sq_hi));

  // sticky flag for a pushed root that does not bracket its operand
  always_ff @(posedge clk_i or negedge enb_i) begin
    if (!enb_i) begin
      chk_err <= 1'b0;
    end else if (push && bad) begin
      chk_err <= 1'b1;
    end
  end

  assign chk_err_o = chk_err;
`else
  assign chk_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_sqrt_out_fifo.sv
// Directed bench for sqrt_out_fifo (DEPTH=4, 8-bit fields).
// Expected values are hand-computed constants.
module tb_sqrt_out_fifo;

  logic       clk_i = 1'b0;
  logic       enb_i;
  logic       res_valid_i;
  logic [7:0] res_r_i;
  logic [7:0] res_x_i;
  logic       res_ready_o;
  logic       out_valid_o;
  logic [7:0] out_r_o;
  logic [7:0] out_x_o;
  logic       out_ready_i;
  logic [2:0] count_o;
  logic       full_o;
  logic [7:0] drop_cnt_o;
  logic       chk_err_o;

  int total  = 0;
  int passed = 0;
  int failed = 0;

  sqrt_out_fifo #(
    .DEPTH(4), .R_W(8), .X_W(8), .CNT_W(8)
  ) dut (
    .clk_i      (clk_i),
    .enb_i      (enb_i),
    .res_valid_i(res_valid_i),
    .res_r_i    (res_r_i),
    .res_x_i    (res_x_i),
    .res_ready_o(res_ready_o),
    .out_valid_o(out_valid_o),
    .out_r_o    (out_r_o),
    .out_x_o    (out_x_o),
    .out_ready_i(out_ready_i),
    .count_o    (count_o),
    .full_o     (full_o),
    .drop_cnt_o (drop_cnt_o),
    .chk_err_o  (chk_err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // one clock: drive, take the edge, sample 1 time unit later
  task automatic cyc(input logic v, input logic [7:0] r,
                     input logic [7:0] x, input logic rdy);
    res_valid_i = v;
    res_r_i     = r;
    res_x_i     = x;
    out_ready_i = rdy;
    @(posedge clk_i);
    #1;
    res_valid_i = 1'b0;
    out_ready_i = 1'b0;
  endtask

  initial begin
    enb_i       = 1'b0;
    res_valid_i = 1'b0;
    res_r_i     = '0;
    res_x_i     = '0;
    out_ready_i = 1'b0;
    #3;
    check("rst_valid", out_valid_o, 0);
    check("rst_count", count_o, 0);
    check("rst_full",  full_o, 0);
    check("rst_ready", res_ready_o, 1);
    check("rst_drop",  drop_cnt_o, 0);
    check("rst_chk",   chk_err_o, 0);
    #9;
    enb_i = 1'b1;

    // basic push then pop
    cyc(1, 4, 16, 0);
    check("b_valid", out_valid_o, 1);
    check("b_r",     out_r_o, 4);
    check("b_x",     out_x_o, 16);
    check("b_count", count_o, 1);
    cyc(0, 0, 0, 1);
    check("b_valid0", out_valid_o, 0);
    check("b_count0", count_o, 0);

    // fill and overflow
    cyc(1, 1, 1, 0);
    cyc(1, 2, 4, 0);
    cyc(1, 3, 9, 0);
    check("f_count3", count_o, 3);
    check("f_full3",  full_o, 0);
    cyc(1, 4, 16, 0);
    check("f_full",  full_o, 1);
    check("f_ready", res_ready_o, 0);
    check("f_count", count_o, 4);
    cyc(1, 5, 25, 0);
    check("ov_drop",  drop_cnt_o, 1);
    check("ov_count", count_o, 4);
    check("ov_head",  out_r_o, 1);
    // push+pop at full: pop only
    cyc(1, 6, 36, 1);
    check("pf_count", count_o, 3);
    check("pf_drop",  drop_cnt_o, 2);
    check("pf_head",  out_r_o, 2);
    check("pf_headx", out_x_o, 4);
    cyc(0, 0, 0, 1);
    check("pop_3", out_r_o, 3);
    cyc(0, 0, 0, 1);
    check("pop_4", out_r_o, 4);
    check("pop_4x", out_x_o, 16);
    cyc(0, 0, 0, 1);
    check("pop_empty", out_valid_o, 0);
    cyc(0, 0, 0, 1);
    check("pop_under", count_o, 0);

    // push+pop at count 2
    cyc(1, 7, 49, 0);
    cyc(1, 8, 64, 0);
    check("pp_count2", count_o, 2);
    check("pp_head7",  out_r_o, 7);
    cyc(1, 9, 81, 1);
    check("pp_count", count_o, 2);
    check("pp_head8", out_r_o, 8);
    cyc(0, 0, 0, 1);
    check("pp_head9", out_r_o, 9);
    check("pp_x9",    out_x_o, 81);
    cyc(0, 0, 0, 1);
    check("pp_empty", count_o, 0);

    // wrap-around streaming
    for (int k = 0; k < 10; k++) begin
      cyc(1, 8'(k), 8'(k * k), 1);
      check($sformatf("wr_r%0d", k), out_r_o, k);
      check($sformatf("wr_x%0d", k), out_x_o, k * k);
      check($sformatf("wr_c%0d", k), count_o, 1);
    end
    cyc(0, 0, 0, 1);
    check("wr_end", count_o, 0);

    // asynchronous reset mid-operation
    cyc(1, 10, 100, 0);
    cyc(1, 11, 121, 0);
    cyc(1, 12, 144, 0);
    check("ar_count3", count_o, 3);
    #2;
    enb_i = 1'b0;
    #1;
    check("ar_valid", out_valid_o, 0);
    check("ar_count", count_o, 0);
    check("ar_ready", res_ready_o, 1);
    check("ar_drop",  drop_cnt_o, 0);
    #2;
    enb_i = 1'b1;
    cyc(1, 13, 169, 0);
    check("ar_head",  out_r_o, 13);
    check("ar_headx", out_x_o, 169);
    check("ar_cnt1",  count_o, 1);
    cyc(0, 0, 0, 1);

    // drop counter saturation, storage untouched
    cyc(1, 20, 1, 0);
    cyc(1, 21, 2, 0);
    cyc(1, 22, 3, 0);
    cyc(1, 23, 4, 0);
    for (int i = 0; i < 300; i++) begin
      cyc(1, 8'hee, 8'hee, 0);
    end
    check("sat_drop", drop_cnt_o, 255);
    check("sat_head", out_r_o, 20);
    check("sat_x",    out_x_o, 1);
    check("sat_cnt",  count_o, 4);

`ifdef SQRT_OUT_CHECK_EN
    enb_i = 1'b0;
    #2;
    enb_i = 1'b1;
    cyc(1, 5, 16, 0);
    check("ck_err", chk_err_o, 1);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 0);
    check("ck_sticky", chk_err_o, 1);
    enb_i = 1'b0;
    #2;
    check("ck_rst", chk_err_o, 0);
    enb_i = 1'b1;
    cyc(1, 4, 24, 0);
    check("ck_ok", chk_err_o, 0);
`else
    check("ck_off", chk_err_o, 0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/sqrt_out_fifo.md
Name: sqrt_out_fifo

Overview:
- Downstream stage of the square-root controller/datapath.
- Captures each finished result, i.e. the root R together with its operand X, on the one-cycle result-valid pulse issued in the controller's END state.
- Buffers results in a small FIFO and presents them to the consumer over a valid/ready handshake.
- Drives ready back to the controller. Counts results dropped on overflow.

Parameters:
- DEPTH, 4, number of FIFO entries; power of two, at least 2.
- R_W, 8, width of the root field.
- X_W, 8, width of the operand tag field.
- CNT_W, 8, width of the saturating drop counter.

Ports:
- clk_i  input  1  clock; all logic on the rising edge.
- enb_i  input  1  asynchronous active-low reset; all state clears while low.
- res_valid_i  input  1  one-cycle result pulse from the controller (its valid_o).
- res_r_i  input  R_W  root value from the R register.
- res_x_i  input  X_W  operand the root was computed from.
- res_ready_o  output  1  space available; feeds the controller's ready input.
- out_valid_o  output  1  head entry available.
- out_r_o  output  R_W  head root.
- out_x_o  output  X_W  head operand.
- out_ready_i  input  1  consumer accepts the head entry.
- count_o  output  $clog2(DEPTH)+1  current occupancy.
- full_o  output  1  count_o == DEPTH.
- drop_cnt_o  output  CNT_W  saturating count of rejected pushes.
- chk_err_o  output  1  sticky result-check error (optional feature only).

Behaviour:
- Reset (enb_i low, asynchronous):
  - wr_ptr, rd_ptr, count and drop_cnt_o go to 0.
  - out_valid_o=0, full_o=0, res_ready_o=1, chk_err_o=0.
  - out_r_o and out_x_o are don't-care while out_valid_o=0.
  - Storage array is not cleared.
  - Reset mid-operation discards all buffered entries.
- Push: res_valid_i=1 and full_o=0.
  - Entry {res_r_i, res_x_i} is written at wr_ptr.
  - wr_ptr increments modulo DEPTH.
- Pop: out_valid_o=1 and out_ready_i=1.
  - rd_ptr increments modulo DEPTH.
  - out_ready_i while empty has no effect.
- Show-ahead FIFO:
  - out_r_o/out_x_o are driven combinationally from storage[rd_ptr].
  - out_valid_o = (count != 0).
- Latency:
  - An entry pushed at edge N is visible on the outputs after edge N.
  - No same-cycle fall-through from input to output when empty.
- Push and pop in the same cycle:
  - Not full: both occur and count is unchanged.
  - Full: only the pop occurs. The push is rejected because the full decision uses registered count, not the concurrent pop.
- Overflow: res_valid_i=1 while full_o=1.
  - Entry is dropped and storage is unchanged.
  - drop_cnt_o increments, saturating at 2^CNT_W-1 and holding there.
- res_ready_o = !full_o; it is derived from registered state only.
  - The controller must only finish a result when res_ready_o=1. The drop path is the safety net.
- Empty/full counter:
  - count increments on push-only and decrements on pop-only.
  - count never exceeds DEPTH and never underflows.
- Pointers wrap silently. Ordering is strict FIFO across wrap.
- Output stability:
  - While out_valid_o=1 and out_ready_i=0, out_r_o/out_x_o hold stable.
  - A concurrent push does not alter the head entry.
- Widths: no arithmetic on the data fields; they are stored and returned bit-exact.

Optional Feature:
- Macro: SQRT_OUT_CHECK_EN.
- Defined: on each accepted push, check res_r_i*res_r_i <= res_x_i < (res_r_i+1)*(res_r_i+1).
  - Products are computed at 2*R_W+2 bits; no truncation.
  - A failed check sets chk_err_o on the following edge. It stays set until reset.
  - The entry is still stored.
- Not defined: no multiplier logic, and chk_err_o is tied to 0.

Test Plan:
- Basic: after reset, pulse res_valid_i with r=4, x=16 and out_ready_i=0 → next cycle out_valid_o=1, out_r_o=4, out_x_o=16, count_o=1. Raise out_ready_i for one cycle → out_valid_o=0, count_o=0.
- Full and overflow (DEPTH=4): push x=1,4,9,16 with r=1,2,3,4 → full_o=1, res_ready_o=0. Fifth push r=5, x=25 → dropped, drop_cnt_o=1. Pops return roots 1,2,3,4 in order.
- Push and pop at count_o=2 → count_o stays 2; head advances to the second entry. Same at full → pop only, count_o=3, push counted as a drop.
- Wrap-around: 10 back-to-back push+pop cycles with x=k*k, r=k for k=0..9 → outputs emerge in order with one cycle of latency; count_o stays at most 1.
- Reset mid-operation: with count_o=3, pull enb_i low mid-cycle → out_valid_o=0, count_o=0, res_ready_o=1 immediately, without waiting for a clock edge. After release, the next push appears as the head.
- SQRT_OUT_CHECK_EN: push r=5, x=16 → chk_err_o=1 on the next cycle and it stays set. Push r=4, x=24 in a fresh run → chk_err_o stays 0.
